alarm_controller: RTL and testbench

Top-level arming/alarm state machine for the alarm system. Takes synchronised button and zone-sensor inputs and drives the ten-second timer through its enable/load inputs. Consumes the timer's terminal-count flag to time exit delay, entry delay and siren duration. Drives the siren, armed indicator and trip-zone status outputs.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/sync_edge.sv | 44 ++++
 rtl/alarm_controller.sv | 163 ++++++++++++++++
 tb/tb_alarm_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encodings, parameter defaults and a small helper for the alarm system.
package alarm_pkg;

    localparam int DEF_ZONES        = 4;
    localparam int DEF_SIREN_CYCLES = 18;

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_EXIT     = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_ENTRY    = 3'd3;
    localparam logic [2:0] ST_ALARM    = 3'd4;
    localparam logic [2:0] ST_SILENCED = 3'd5;

    // States that run the ten-second timer.
    function automatic logic is_timed(input logic [2:0] s);
        return (s == ST_EXIT) || (s == ST_ENTRY) || (s == ST_ALARM);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with an optional rising-edge strobe output.
module sync_edge #(
    parameter int WIDTH = 1,
    parameter bit EDGE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    // NOTE: non-blocking assignments keep the two stages as distinct flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic [WIDTH-1:0] s3_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s3_q <= '0;
                end else begin
                    s3_q <= s2_q;
                end
            end

            assign q = s2_q & ~s3_q;
        end else begin : g_level
            assign q = s2_q;
        end
    endgenerate

endmodule

// File: rtl/alarm_controller.sv
// Arming/alarm state machine: drives the ten-second timer, siren, armed LED and trip-zone latch.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int               ZONES        = DEF_ZONES,
    parameter logic [ZONES-1:0] INSTANT_MASK = 4'b1100,
    parameter int               SIREN_CYCLES = DEF_SIREN_CYCLES
) (
    input  logic             clock50,
    input  logic             Mr,
    input  logic             arm_btn,
    input  logic             disarm_btn,
    input  logic [ZONES-1:0] zone,
    input  logic             timer_tc,
    output logic             timer_en,
    output logic             timer_load,
    output logic             siren,
    output logic             armed_led,
    output logic             arm_fault,
    output logic [2:0]       state_code,
    output logic [ZONES-1:0] trip_zone
);

    localparam int CNT_W = $clog2(SIREN_CYCLES + 1);

    logic [1:0]       btn_p;
    logic             arm_p;
    logic             disarm_p;
    logic [ZONES-1:0] zone_s;

    sync_edge #(.WIDTH(2), .EDGE(1'b1)) u_btn_sync (
        .clk   (clock50),
        .rst_n (Mr),
        .d     ({disarm_btn, arm_btn}),
        .q     (btn_p)
    );

    sync_edge #(.WIDTH(ZONES), .EDGE(1'b0)) u_zone_sync (
        .clk   (clock50),
        .rst_n (Mr),
        .d     (zone),
        .q     (zone_s)
    );

    assign arm_p    = btn_p[0];
    assign disarm_p = btn_p[1];

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ZONES-1:0] trip_q, trip_d;
    logic             siren_q, siren_d;
    logic             led_q, led_d;
    logic             fault_q, fault_d;
    logic             en_q, en_d;
    logic             load_q, load_d;
    logic             tc_prev_q;

    logic             tc_v;
    logic             reload;
    logic [ZONES-1:0] inst_hits;
    logic [ZONES-1:0] dly_hits;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [ZONES-1:0] lowest_one(input logic [ZONES-1:0] v);
        return v & (~v + ZONES'(1));
    endfunction

    // An expiry landing on a reload cycle refers to the old count and is dropped.
    assign tc_v      = timer_tc & ~tc_prev_q & ~load_q;
    assign inst_hits = zone_s & INSTANT_MASK;
    assign dly_hits  = zone_s & ~INSTANT_MASK;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trip_d  = trip_q;
        fault_d = 1'b0;
        reload  = 1'b0;

        if (disarm_p) begin
            state_d = ST_DISARMED;
            cnt_d   = '0;
            trip_d  = '0;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (arm_p) begin
                        if (|zone_s) fault_d = 1'b1;
                        else         state_d = ST_EXIT;
                    end
                end
                ST_EXIT: begin
                    if (tc_v) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (|inst_hits) begin
                        state_d = ST_ALARM;
                        trip_d  = lowest_one(inst_hits);
                    end else if (|dly_hits) begin
                        state_d = ST_ENTRY;
                        trip_d  = lowest_one(dly_hits);
                    end
                end
                ST_ENTRY: begin
                    if (tc_v || (|inst_hits)) state_d = ST_ALARM;
                end
                ST_ALARM: begin
                    if (tc_v) begin
                        reload = 1'b1;
                        if (cnt_inc == CNT_W'(SIREN_CYCLES)) begin
                            state_d = ST_SILENCED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_SILENCED: ;
                default: state_d = ST_DISARMED;
            endcase
        end

        load_d  = (is_timed(state_d) && (state_d != state_q)) || reload;
        en_d    = is_timed(state_d) && !load_d;
        siren_d = (state_d == ST_ALARM);
        led_d   = (state_d != ST_DISARMED);
    end

    always_ff @(posedge clock50 or negedge Mr) begin
        if (!Mr) begin
            state_q   <= ST_DISARMED;
            cnt_q     <= '0;
            trip_q    <= '0;
            siren_q   <= 1'b0;
            led_q     <= 1'b0;
            fault_q   <= 1'b0;
            en_q      <= 1'b0;
            load_q    <= 1'b0;
            tc_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trip_q    <= trip_d;
            siren_q   <= siren_d;
            led_q     <= led_d;
            fault_q   <= fault_d;
            en_q      <= en_d;
            load_q    <= load_d;
            tc_prev_q <= timer_tc;
        end
    end

    assign state_code = state_q;
    assign trip_zone  = trip_q;
    assign siren      = siren_q;
    assign armed_led  = led_q;
    assign arm_fault  = fault_q;
    assign timer_en   = en_q;
    assign timer_load = load_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: vector table plus hand-written corner sequences.
module tb_alarm_controller;
    import alarm_pkg::*;

    localparam int ZONES = 4;

    logic             clock50 = 1'b0;
    logic             Mr;
    logic             arm_btn;
    logic             disarm_btn;
    logic             timer_tc;
    logic [ZONES-1:0] zone;
    logic             timer_en;
    logic             timer_load;
    logic             siren;
    logic             armed_led;
    logic             arm_fault;
    logic [2:0]       state_code;
    logic [ZONES-1:0] trip_zone;

    alarm_controller #(
        .ZONES        (ZONES),
        .INSTANT_MASK (4'b1100),
        .SIREN_CYCLES (3)
    ) dut (
        .clock50    (clock50),
        .Mr         (Mr),
        .arm_btn    (arm_btn),
        .disarm_btn (disarm_btn),
        .zone       (zone),
        .timer_tc   (timer_tc),
        .timer_en   (timer_en),
        .timer_load (timer_load),
        .siren      (siren),
        .armed_led  (armed_led),
        .arm_fault  (arm_fault),
        .state_code (state_code),
        .trip_zone  (trip_zone)
    );

    always #10 clock50 = ~clock50;

    typedef struct packed {
        logic [2:0] st;
        logic       ld;
        logic       en;
        logic       si;
        logic       led;
        logic       flt;
        logic [3:0] trip;
    } out_t;

    typedef struct {
        logic       arm;
        logic       dis;
        logic       tc;
        logic [3:0] zone;
        int         waits;
        out_t       exp;
    } vec_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    out_t exp_q[$];
    vec_t vecs[$];

    function automatic out_t o(input logic [2:0] st, input logic ld, input logic en,
                               input logic si, input logic led, input logic flt,
                               input logic [3:0] trip);
        return '{st, ld, en, si, led, flt, trip};
    endfunction

    function automatic vec_t v(input logic a, input logic d, input logic t,
                               input logic [3:0] z, input int w, input out_t e);
        return '{a, d, t, z, w, e};
    endfunction

    function automatic out_t dut_out();
        return '{state_code, timer_load, timer_en, siren, armed_led, arm_fault, trip_zone};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock50);
    endtask

    task automatic drive(input logic a, input logic d, input logic t, input logic [3:0] z);
        arm_btn    = a;
        disarm_btn = d;
        timer_tc   = t;
        zone       = z;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Pops the oldest expected output record and compares it with the DUT outputs now.
    task automatic check_out(input string name);
        out_t want;
        out_t got;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: no expected record queued", name);
            return;
        end
        want = exp_q.pop_front();
        got  = dut_out();
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got st=%0d ld=%b en=%b si=%b led=%b flt=%b trip=%b, expected st=%0d ld=%b en=%b si=%b led=%b flt=%b trip=%b",
                     name, got.st, got.ld, got.en, got.si, got.led, got.flt, got.trip,
                     want.st, want.ld, want.en, want.si, want.led, want.flt, want.trip);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (state_code !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(state_code), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                arm dis tc zone    w   st ld en si led flt trip
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(1, 0, 0, 4'b0000, 3, o(1, 1, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(1, 0, 1, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 1, 4'b0000, 1, o(2, 0, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(2, 0, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0001, 3, o(3, 1, 0, 0, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 0, 4'b0001, 1, o(3, 0, 1, 0, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 1, 4'b0001, 1, o(4, 1, 0, 1, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 0, 4'b0001, 1, o(4, 0, 1, 1, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 1, 4'b0001, 1, o(4, 1, 0, 1, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 0, 4'b0001, 1, o(4, 0, 1, 1, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 1, 4'b0001, 1, o(4, 1, 0, 1, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 0, 4'b0001, 1, o(4, 0, 1, 1, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 1, 4'b0001, 1, o(5, 1, 0, 0, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 0, 4'b0001, 1, o(5, 0, 0, 0, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 0, 0, 4'b1111, 4, o(5, 0, 0, 0, 1, 0, 4'b0001)));
        vecs.push_back(v(0, 1, 0, 4'b0000, 3, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0010, 3, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(1, 0, 0, 4'b0010, 3, o(0, 0, 0, 0, 0, 1, 4'b0000)));
        vecs.push_back(v(1, 0, 0, 4'b0010, 1, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 3, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(1, 0, 0, 4'b0000, 3, o(1, 1, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(1, 0, 1, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 1, 4'b0000, 1, o(2, 0, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0101, 3, o(4, 1, 0, 1, 1, 0, 4'b0100)));
        vecs.push_back(v(0, 0, 0, 4'b0101, 1, o(4, 0, 1, 1, 1, 0, 4'b0100)));
        vecs.push_back(v(0, 1, 0, 4'b0000, 3, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(1, 0, 0, 4'b0000, 3, o(1, 1, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(1, 0, 1, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 1, 4'b0000, 1, o(2, 0, 0, 0, 1, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0010, 3, o(3, 1, 0, 0, 1, 0, 4'b0010)));
        vecs.push_back(v(0, 0, 0, 4'b1010, 3, o(4, 1, 0, 1, 1, 0, 4'b0010)));
        vecs.push_back(v(0, 1, 0, 4'b0000, 3, o(0, 0, 0, 0, 0, 0, 4'b0000)));
        vecs.push_back(v(0, 0, 0, 4'b0000, 1, o(0, 0, 0, 0, 0, 0, 4'b0000)));

        Mr = 1'b1;
        drive(0, 0, 0, 4'b0000);
        #1 Mr = 1'b0;
        tick(2);
        exp_q.push_back(o(0, 0, 0, 0, 0, 0, 4'b0000));
        check_out("reset_held");
        Mr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].arm, vecs[i].dis, vecs[i].tc, vecs[i].zone);
            exp_q.push_back(vecs[i].exp);
            tick(vecs[i].waits);
            check_out($sformatf("vec%0d", i));
        end

        // Expiry during the ENTRY reload cycle is ignored; disarm then beats a same-cycle expiry.
        drive(1, 0, 0, 4'b0000); tick(3);
        drive(0, 0, 0, 4'b0000); tick(1);
        drive(0, 0, 1, 4'b0000); tick(1);
        check("seq_armed", 32'(state_code), 32'(ST_ARMED));
        drive(0, 0, 0, 4'b0001);
        exp_q.push_back(o(3, 1, 0, 0, 1, 0, 4'b0001));
        tick(3);
        check_out("entry_load");
        drive(0, 0, 1, 4'b0001);
        exp_q.push_back(o(3, 0, 1, 0, 1, 0, 4'b0001));
        tick(1);
        check_out("tc_on_load_ignored");
        drive(0, 0, 0, 4'b0001); tick(1);
        drive(0, 1, 0, 4'b0001); tick(2);
        check("still_entry", 32'(state_code), 32'(ST_ENTRY));
        drive(0, 1, 1, 4'b0001);
        exp_q.push_back(o(0, 0, 0, 0, 0, 0, 4'b0000));
        tick(1);
        check_out("disarm_beats_tc");
        drive(0, 0, 0, 4'b0000); tick(3);

        // Asynchronous reset in the middle of ALARM.
        drive(1, 0, 0, 4'b0000); tick(3);
        drive(0, 0, 0, 4'b0000); tick(1);
        drive(0, 0, 1, 4'b0000); tick(1);
        drive(0, 0, 0, 4'b1000);
        wait_state(ST_ALARM, 8, "reach_alarm");
        check("alarm_siren", 32'(siren), 32'd1);
        #3 Mr = 1'b0;
        #1;
        exp_q.push_back(o(0, 0, 0, 0, 0, 0, 4'b0000));
        check_out("reset_async");
        drive(0, 0, 0, 4'b0000);
        tick(2);
        Mr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(o(0, 0, 0, 0, 0, 0, 4'b0000));
            tick(1);
            check_out($sformatf("post_reset_%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
